// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Parametrised pipeline-stage register with a valid/ready handshake and a
//   2-entry skid buffer (head H drives the outputs, skid S catches the beat that
//   arrives while the head is stalled). Supports per-beat kill (the beat still
//   occupies a slot, with ctrl & KILL_MASK forced to 0) and a whole-stage flush.
//   in_ready comes from a register only, so a downstream stall never creates a
//   combinational ready path.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid/in_ready        upstream handshake (in_ready registered, = occ!=2)
//   in_data/in_ctrl/in_kill  upstream beat
//   flush                    drop held beats and the beat offered this cycle
//   out_valid/out_ready      downstream handshake (out_valid = occ!=0)
//   out_data/out_ctrl        head beat (ctrl already masked if killed)
//   out_killed               head beat was killed upstream
//   occ                      occupancy 0..2
//
// state | meaning
// EMPTY | no beat held, outputs invalid
// ONE   | head holds a beat, skid empty
// TWO   | head and skid both hold beats, upstream stalled

module pipe_stage_skid #(
  parameter int                 DATA_W         = 128,
  parameter int                 CTRL_W         = 16,
  parameter logic [CTRL_W-1:0]  KILL_MASK      = '1,
  parameter bit                 CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_killed,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic              in_ready_q, out_valid_q;
  logic [DATA_W-1:0] h_data, s_data;
  logic [CTRL_W-1:0] h_ctrl, s_ctrl;
  logic              h_killed, s_killed;

  logic              acc, pop;
  logic              load_h, load_s, h_from_s;
  logic [CTRL_W-1:0] beat_ctrl;

  assign acc       = in_valid & in_ready_q & ~flush;
  assign pop       = out_valid_q & out_ready;
  assign beat_ctrl = in_kill ? (in_ctrl & ~KILL_MASK) : in_ctrl;

  always_comb begin
    state_nxt = state_q;
    load_h    = 1'b0;
    load_s    = 1'b0;
    h_from_s  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          load_h    = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc && !pop) begin
          load_s    = 1'b1;
          state_nxt = TWO;
        end else if (acc && pop) begin
          load_h    = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          h_from_s  = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush overrides everything; a pop this cycle has already completed
    // downstream, so only the storage update is suppressed.
    if (flush) begin
      state_nxt = EMPTY;
      load_h    = 1'b0;
      load_s    = 1'b0;
      h_from_s  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      in_ready_q  <= (state_nxt != TWO);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_data   <= '0;
      h_ctrl   <= '0;
      h_killed <= 1'b0;
      s_data   <= '0;
      s_ctrl   <= '0;
      s_killed <= 1'b0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        h_data   <= '0;
        h_ctrl   <= '0;
        h_killed <= 1'b0;
        s_data   <= '0;
        s_ctrl   <= '0;
        s_killed <= 1'b0;
      end
    end else begin
      if (load_h) begin
        h_data   <= in_data;
        h_ctrl   <= beat_ctrl;
        h_killed <= in_kill;
      end else if (h_from_s) begin
        h_data   <= s_data;
        h_ctrl   <= s_ctrl;
        h_killed <= s_killed;
      end
      if (load_s) begin
        s_data   <= in_data;
        s_ctrl   <= beat_ctrl;
        s_killed <= in_kill;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = h_data;
  assign out_ctrl   = h_ctrl;
  assign out_killed = h_killed;
  assign occ        = state_q;

  a_no_acc_when_full : assert property (
    @(posedge clk) disable iff (rst) !(acc && state_q == TWO)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int          DW    = 32;
  localparam int          CW    = 16;
  localparam logic [15:0] KMASK = 16'h00F0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_kill, flush;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid, out_ready, out_killed;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occ;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .KILL_MASK(KMASK), .CLEAR_ON_FLUSH(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .in_kill(in_kill), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .out_killed(out_killed), .occ(occ)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          k;
  } beat_t;

  // Reference model: the stage is a FIFO of at most two beats.
  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs 1 time unit after each falling edge, after the driver has
  // set the inputs for the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b0) begin
      chk("occ", 64'(occ), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
      if (exp_q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0].d));
        chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].c));
        chk("out_killed", 64'(out_killed), 64'(exp_q[0].k));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; 'took' is the model's view of acceptance.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic k, input logic f, input logic ordy, output logic took);
    beat_t b;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_kill   = k;
    flush     = f;
    out_ready = ordy;
    took = v && !f && (exp_q.size() < 2);
    #2;
    if (f) exp_q.delete();
    else if (took) begin
      b.d = d;
      b.c = k ? (c & ~KMASK) : c;
      b.k = k;
      exp_q.push_back(b);
    end
  endtask

  task automatic idle(input logic ordy, input int n);
    logic t;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, ordy, t);
  endtask

  // Offer one beat, holding it until accepted, within a cycle budget.
  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic k,
                      input logic ordy, input string name);
    logic t;
    int   n = 0;
    t = 1'b0;
    while (!t && n < 20) begin
      drive(1'b1, d, c, k, 1'b0, ordy, t);
      n++;
    end
    if (!t) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: beat %0h not accepted within 20 cycles", name, d);
    end
  endtask

  initial begin
    logic          t, pend, v, k, f, r;
    logic [DW-1:0] d;
    logic [CW-1:0] c;

    rst = 1'b1;
    in_valid = 0; in_data = '0; in_ctrl = '0; in_kill = 0; flush = 0; out_ready = 0;
    #1;
    chk("reset_occ", 64'(occ), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_data", 64'(out_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1'b1, 2);

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) send(DW'(i), 16'h1000 + 16'(i), 1'b0, 1'b1, "stream");
    idle(1'b1, 3);

    // Back-pressure: A, B fill the stage, C must wait upstream.
    send(32'hA, 16'h000A, 1'b0, 1'b0, "bp_A");
    send(32'hB, 16'h000B, 1'b0, 1'b0, "bp_B");
    drive(1'b1, 32'hC, 16'h000C, 1'b0, 1'b0, 1'b0, t);
    chk("bp_C_refused", 64'(t), 64'd0);
    drive(1'b1, 32'hC, 16'h000C, 1'b0, 1'b0, 1'b0, t);
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    send(32'hC, 16'h000C, 1'b0, 1'b1, "bp_C");
    idle(1'b1, 4);

    // Kill: masked ctrl bits cleared, data untouched.
    drive(1'b1, 32'h1234_5678, 16'hFFFF, 1'b1, 1'b0, 1'b0, t);
    idle(1'b0, 1);
    chk("kill_ctrl", 64'(out_ctrl), 64'h0000_0000_0000_FF0F);
    chk("kill_flag", 64'(out_killed), 64'd1);
    chk("kill_data", 64'(out_data), 64'h0000_0000_1234_5678);
    idle(1'b1, 2);

    // Flush with two held beats and a beat offered in the same cycle.
    send(32'h11, 16'h0011, 1'b0, 1'b0, "fl_1");
    send(32'h22, 16'h0022, 1'b0, 1'b0, "fl_2");
    drive(1'b1, 32'h33, 16'h0033, 1'b0, 1'b1, 1'b0, t);
    idle(1'b0, 1);
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_data", 64'(out_data), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1, 2);

    // Reset mid-stream with the stage full.
    send(32'h44, 16'h0044, 1'b0, 1'b0, "rs_1");
    send(32'h55, 16'h0055, 1'b0, 1'b0, "rs_2");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_occ", 64'(occ), 64'd0);
    chk("rst_mid_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1, 2);

    // Random traffic; an unaccepted beat is held upstream unless flushed.
    pend = 1'b0;
    v = 0; d = '0; c = '0; k = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!pend) begin
        v = ($urandom_range(9) < 7);
        d = $urandom;
        c = 16'($urandom);
        k = ($urandom_range(3) == 0);
      end
      f = ($urandom_range(99) < 3);
      r = ($urandom_range(9) < 6);
      drive(v, d, c, k, f, r, t);
      pend = v && !t && !f;
    end
    idle(1'b1, 4);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
